// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer sequencer.
package timer_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned ENTRY_W      = 16;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned STATE_W      = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min_t;
    logic [BCD_W-1:0] min_u;
    logic [BCD_W-1:0] sec_t;
    logic [BCD_W-1:0] sec_u;
  } entry_t;

  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_W'(9);
  endfunction

endpackage

// File: rtl/timer_control_tick_divider.sv
// Free-running modulo-TICK_DIV divider; wrap marks the last cycle of a tick period.
module tick_divider #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] count;

  assign wrap = (count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timer_control.sv
// Sequencer for the MM:SS down-counting chain: keypad entry, load, tick
// generation, pause/resume and completion handling.
module timer_control
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned DONE_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               keypad_valid,
  input  logic [BCD_W-1:0]   keypad_digit,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  input  logic               timer_zero,
  output logic [ENTRY_W-1:0] entry_data,
  output logic               load_n,
  output logic               count_en,
  output logic               counter_clear_n,
  output logic               running,
  output logic               done,
  output logic               entry_err
);

  localparam int unsigned DCW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_e         state_q, state_d;
  entry_t         entry_q, entry_d, entry_shift_c;
  logic [DCW-1:0] done_cnt_q, done_cnt_d;
  logic           clear_c;
  logic           reject_c;
  logic           key_ok_c;
  logic           bad_entry_c;
  logic           pause_c;
  logic           div_wrap;
  logic           div_en;

  assign entry_data    = entry_q;
  assign key_ok_c      = keypad_valid && digit_ok(keypad_digit);
  assign entry_shift_c = entry_t'({entry_q.min_u, entry_q.sec_t, entry_q.sec_u, keypad_digit});
  assign bad_entry_c   = (entry_q == '0) || (entry_q.sec_t > BCD_W'(SEC_TENS_MAX)) || !door_closed;
  assign pause_c       = !door_closed || stop_clear;

  // Divider holds while pausing, except that a wrap cycle completes its tick
  // so the resumed run never issues the same tick twice.
  assign div_en   = (state_q == ST_RUN) && (!pause_c || div_wrap);
  assign count_en = (state_q == ST_RUN) && div_wrap && !timer_zero;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clock(clock),
    .reset(reset),
    .en   (div_en),
    .clr  (state_q == ST_LOAD),
    .wrap (div_wrap)
  );

  // Next-state and entry register decode.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    done_cnt_d = '0;
    clear_c    = 1'b0;
    reject_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_ok_c) begin
          entry_d = entry_shift_c;
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        if (stop_clear) begin
          clear_c = 1'b1;
        end else if (start) begin
          if (bad_entry_c) reject_c = 1'b1;
          else             state_d  = ST_LOAD;
        end else if (key_ok_c) begin
          entry_d = entry_shift_c;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (pause_c)         state_d = ST_PAUSE;
        else if (timer_zero) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (stop_clear)                clear_c = 1'b1;
        else if (start && door_closed) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (stop_clear || (done_cnt_q == DCW'(DONE_CYCLES - 1))) clear_c = 1'b1;
        else done_cnt_d = done_cnt_q + DCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_c) begin
      state_d = ST_IDLE;
      entry_d = '0;
    end
  end

  // State register with Moore outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      entry_q         <= '0;
      done_cnt_q      <= '0;
      load_n          <= 1'b1;
      running         <= 1'b0;
      done            <= 1'b0;
      entry_err       <= 1'b0;
      counter_clear_n <= 1'b0;
    end else begin
      state_q         <= state_d;
      entry_q         <= entry_d;
      done_cnt_q      <= done_cnt_d;
      load_n          <= (state_d != ST_LOAD);
      running         <= (state_d == ST_RUN);
      done            <= (state_d == ST_DONE);
      entry_err       <= reject_c;
      counter_clear_n <= !clear_c;
    end
  end

endmodule

// File: tb/tb_timer_control.sv
// Directed bench for timer_control with a BCD MM:SS down-counter chain model.
module tb_timer_control;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DONE_CYCLES = 3;
  localparam int          NVEC        = 17;

  logic        clock = 1'b0;
  logic        reset;
  logic        keypad_valid;
  logic [3:0]  keypad_digit;
  logic        start;
  logic        stop_clear;
  logic        door_closed;
  logic        timer_zero;
  logic [15:0] entry_data;
  logic        load_n;
  logic        count_en;
  logic        counter_clear_n;
  logic        running;
  logic        done;
  logic        entry_err;

  logic [15:0] chain = 16'h0000;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  dig;
    logic        st;
    logic        sc;
    logic        door;
    logic [15:0] entry;
    logic        load_n;
    logic        run;
    logic        done;
    logic        err;
    logic        clr_n;
    logic        cen;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clock = ~clock;

  timer_control #(
    .TICK_DIV   (TICK_DIV),
    .DONE_CYCLES(DONE_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .keypad_valid   (keypad_valid),
    .keypad_digit   (keypad_digit),
    .start          (start),
    .stop_clear     (stop_clear),
    .door_closed    (door_closed),
    .timer_zero     (timer_zero),
    .entry_data     (entry_data),
    .load_n         (load_n),
    .count_en       (count_en),
    .counter_clear_n(counter_clear_n),
    .running        (running),
    .done           (done),
    .entry_err      (entry_err)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = (mt != 4'd0) ? mt - 4'd1 : 4'd9;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Counter chain: clear has priority, then synchronous load, then count.
  assign timer_zero = (chain == 16'h0000);
  always @(posedge clock) begin
    if (!counter_clear_n)  chain <= 16'h0000;
    else if (!load_n)      chain <= entry_data;
    else if (count_en)     chain <= bcd_dec(chain);
  end

  function automatic vec_t mk(input logic kv, input logic [3:0] dig, input logic st,
                              input logic sc, input logic door, input logic [15:0] entry,
                              input logic ln, input logic run, input logic dn,
                              input logic err, input logic clr_n, input logic cen);
    vec_t v;
    v.kv = kv; v.dig = dig; v.st = st; v.sc = sc; v.door = door;
    v.entry = entry; v.load_n = ln; v.run = run; v.done = dn;
    v.err = err; v.clr_n = clr_n; v.cen = cen;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_entry, input logic e_ln,
                           input logic e_run, input logic e_done, input logic e_err,
                           input logic e_clr, input logic e_cen);
    check($sformatf("%s.entry_data", tag), entry_data, e_entry);
    check($sformatf("%s.load_n", tag), 16'(load_n), 16'(e_ln));
    check($sformatf("%s.running", tag), 16'(running), 16'(e_run));
    check($sformatf("%s.done", tag), 16'(done), 16'(e_done));
    check($sformatf("%s.entry_err", tag), 16'(entry_err), 16'(e_err));
    check($sformatf("%s.counter_clear_n", tag), 16'(counter_clear_n), 16'(e_clr));
    check($sformatf("%s.count_en", tag), 16'(count_en), 16'(e_cen));
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic apply(input logic kv, input logic [3:0] dig, input logic st, input logic sc);
    keypad_valid = kv;
    keypad_digit = dig;
    start        = st;
    stop_clear   = sc;
    @(posedge clock);
    #1;
    keypad_valid = 1'b0;
    start        = 1'b0;
    stop_clear   = 1'b0;
  endtask

  task automatic idle();
    apply(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    apply(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    int first;
    int cyc;
    int dl;

    vecs[0]  = mk(0, 4'h0, 1, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 4'h9, 0, 0, 1, 16'h0009, 1, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 4'h9, 0, 0, 1, 16'h0099, 1, 0, 0, 0, 1, 0);
    vecs[3]  = mk(0, 4'h0, 1, 0, 1, 16'h0099, 1, 0, 0, 1, 1, 0);
    vecs[4]  = mk(0, 4'h0, 0, 0, 1, 16'h0099, 1, 0, 0, 0, 1, 0);
    vecs[5]  = mk(1, 4'hA, 0, 0, 1, 16'h0099, 1, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 4'h0, 0, 1, 1, 16'h0000, 1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 4'h0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, 4'h0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 4'h0, 1, 0, 1, 16'h0000, 1, 0, 0, 1, 1, 0);
    vecs[10] = mk(1, 4'h3, 0, 0, 1, 16'h0003, 1, 0, 0, 0, 1, 0);
    vecs[11] = mk(0, 4'h0, 1, 0, 0, 16'h0003, 1, 0, 0, 1, 1, 0);
    vecs[12] = mk(1, 4'h2, 1, 0, 1, 16'h0003, 0, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 4'h0, 0, 0, 1, 16'h0003, 1, 1, 0, 0, 1, 0);
    vecs[14] = mk(0, 4'h0, 0, 1, 1, 16'h0003, 1, 0, 0, 0, 1, 0);
    vecs[15] = mk(0, 4'h0, 1, 1, 1, 16'h0000, 1, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 4'h0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 0);

    reset        = 1'b1;
    keypad_valid = 1'b0;
    keypad_digit = 4'h0;
    start        = 1'b0;
    stop_clear   = 1'b0;
    door_closed  = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all("reset", 16'h0000, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    idle();
    check("post_reset.counter_clear_n", 16'(counter_clear_n), 16'd1);

    // Entry, rejection, pause and clear vectors.
    for (int i = 0; i < NVEC; i++) begin
      door_closed = vecs[i].door;
      apply(vecs[i].kv, vecs[i].dig, vecs[i].st, vecs[i].sc);
      check_all($sformatf("vec%0d", i), vecs[i].entry, vecs[i].load_n, vecs[i].run,
                vecs[i].done, vecs[i].err, vecs[i].clr_n, vecs[i].cen);
    end
    door_closed = 1'b1;

    // 01:05 full run to completion.
    key(4'h0); key(4'h1); key(4'h0); key(4'h5);
    check("run.entry_data", entry_data, 16'h0105);
    apply(1'b0, 4'h0, 1'b1, 1'b0);
    check("run.load_n_low", 16'(load_n), 16'd0);
    check("run.running_in_load", 16'(running), 16'd0);
    idle();
    check("run.running", 16'(running), 16'd1);
    check("run.load_n_high", 16'(load_n), 16'd1);
    ticks = 0;
    first = -1;
    cyc   = 0;
    while (!done && cyc < 1000) begin
      if (count_en) begin
        if (first < 0) first = cyc;
        ticks++;
      end
      idle();
      cyc++;
    end
    check("run.done_reached", 16'(done), 16'd1);
    check("run.tick_count", 16'(ticks), 16'd65);
    check("run.first_tick", 16'(first), 16'(TICK_DIV - 1));
    check("run.chain_zero", chain, 16'h0000);
    dl = 0;
    while (done && dl < 10) begin
      dl++;
      idle();
    end
    check("run.done_len", 16'(dl), 16'(DONE_CYCLES));
    check_all("run.end", 16'h0000, 1, 0, 0, 0, 0, 0);
    idle();
    check("run.clear_release", 16'(counter_clear_n), 16'd1);

    // Door opens at divider 2, resume continues from 2.
    key(4'h1); key(4'h0);
    apply(1'b0, 4'h0, 1'b1, 1'b0);
    idle();
    check("door.running", 16'(running), 16'd1);
    idle();
    idle();
    check("door.no_tick_div2", 16'(count_en), 16'd0);
    door_closed = 1'b0;
    idle();
    check_all("door.paused", 16'h0010, 1, 0, 0, 0, 1, 0);
    apply(1'b0, 4'h0, 1'b1, 1'b0);
    check_all("door.start_open", 16'h0010, 1, 0, 0, 0, 1, 0);
    door_closed = 1'b1;
    apply(1'b0, 4'h0, 1'b1, 1'b0);
    check("door.resumed", 16'(running), 16'd1);
    check("door.resume_no_tick", 16'(count_en), 16'd0);
    idle();
    check("door.resume_tick", 16'(count_en), 16'd1);
    check("door.chain", chain, 16'h0010);
    apply(1'b0, 4'h0, 1'b0, 1'b1);
    check("door.stop_pause", 16'(running), 16'd0);
    apply(1'b0, 4'h0, 1'b0, 1'b1);
    check_all("door.cleared", 16'h0000, 1, 0, 0, 0, 0, 0);
    idle();

    // Reset asserted while running.
    key(4'h2);
    apply(1'b0, 4'h0, 1'b1, 1'b0);
    idle();
    check("rst.running", 16'(running), 16'd1);
    idle();
    reset = 1'b1;
    idle();
    check_all("rst.mid_run", 16'h0000, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    idle();
    check_all("rst.release", 16'h0000, 1, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
